// File: rtl/dcache_wb.sv
// Direct-mapped write-back, write-allocate data cache between the core's
// word port and the 128-bit line memory. Hits finish with no stall.
module dcache_wb #(
  parameter int BLOCKS = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         proc_read,
  input  logic         proc_write,
  input  logic [29:0]  proc_addr,
  input  logic [31:0]  proc_wdata,
  output logic         proc_stall,
  output logic [31:0]  proc_rdata,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready
);

  // state     | meaning
  // IDLE      | serve hits, detect misses
  // WRITEBACK | dirty victim line being written to memory
  // ALLOCATE  | new line being fetched from memory
  localparam int INDEX_W = $clog2(BLOCKS);
  localparam int TAG_W   = 28 - INDEX_W;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

  state_t state_q, state_d;

  logic [BLOCKS-1:0] valid_q;
  logic [BLOCKS-1:0] dirty_q;
  logic [TAG_W-1:0]  tag_q  [BLOCKS];
  logic [127:0]      data_q [BLOCKS];

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   ptag;
  logic [6:0]         wbit;
  logic               req;
  logic               hit;
  logic               wr_hit;
  logic               fill;

  assign idx  = proc_addr[INDEX_W+1:2];
  assign ptag = proc_addr[29:INDEX_W+2];
  assign wbit = {proc_addr[1:0], 5'b0};
  assign req  = proc_read | proc_write;
  assign hit  = valid_q[idx] && (tag_q[idx] == ptag);

  assign proc_rdata = data_q[idx][wbit +: 32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    proc_stall = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    wr_hit     = 1'b0;
    fill       = 1'b0;
    case (state_q)
      IDLE: begin
        if (req && !hit) begin
          proc_stall = 1'b1;
          state_d    = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : ALLOCATE;
        end else if (proc_write) begin
          wr_hit = 1'b1;
        end
      end
      WRITEBACK: begin
        proc_stall = 1'b1;
        mem_write  = 1'b1;
        mem_addr   = {tag_q[idx], idx};
        mem_wdata  = data_q[idx];
        if (mem_ready) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        proc_stall = 1'b1;
        mem_read   = 1'b1;
        mem_addr   = {ptag, idx};
        if (mem_ready) begin
          fill    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A write miss is merged on the IDLE cycle after the refill, so fill
  // always clears dirty and the follow-up write hit sets it again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
      for (int i = 0; i < BLOCKS; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else if (fill) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
      tag_q[idx]   <= ptag;
      data_q[idx]  <= mem_rdata;
    end else if (wr_hit) begin
      dirty_q[idx]             <= 1'b1;
      data_q[idx][wbit +: 32]  <= proc_wdata;
    end
  end

endmodule

// File: tb/tb_dcache_wb.sv
// Bench for dcache_wb: directed and random accesses checked against a
// line-level cache model plus a backing-store model of main memory.
module tb_dcache_wb;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         proc_read = 1'b0;
  logic         proc_write = 1'b0;
  logic [29:0]  proc_addr = '0;
  logic [31:0]  proc_wdata = '0;
  logic         proc_stall;
  logic [31:0]  proc_rdata;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata = '0;
  logic         mem_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  bit           m_valid [8];
  bit           m_dirty [8];
  logic [24:0]  m_tag   [8];
  logic [127:0] m_data  [8];
  logic [127:0] mem [logic [27:0]];

  dcache_wb #(.BLOCKS(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .proc_read(proc_read), .proc_write(proc_write),
    .proc_addr(proc_addr), .proc_wdata(proc_wdata),
    .proc_stall(proc_stall), .proc_rdata(proc_rdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mem_line(input logic [27:0] a);
    if (!mem.exists(a)) mem[a] = {$urandom, $urandom, $urandom, $urandom};
    return mem[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
      m_tag[i]   = '0;
      m_data[i]  = '0;
    end
  endtask

  // One core access, held until complete; d_wb/d_al are the extra cycles
  // before mem_ready in each memory phase, spur pulses mem_ready in IDLE.
  task automatic access(input bit rd, input bit wr, input logic [29:0] a,
                        input logic [31:0] wd, input int d_wb, input int d_al,
                        input bit spur);
    logic [2:0]  idx;
    logic [24:0] tg;
    int          w;
    int          stalls;
    bit          hit;
    bit          wb;
    idx = a[4:2];
    tg  = a[29:5];
    w   = int'(a[1:0]);
    stalls = 0;
    wb  = 0;
    proc_read = rd; proc_write = wr; proc_addr = a; proc_wdata = wd;
    hit = m_valid[idx] && (m_tag[idx] == tg);
    if (!hit) begin
      wb = m_valid[idx] && m_dirty[idx];
      @(negedge clk);
      chk("miss_stall", proc_stall, 1);
      if (proc_stall) stalls++;
      @(posedge clk); #1;
      if (wb) begin
        for (int c = 0; c <= d_wb; c++) begin
          mem_ready = (c == d_wb);
          @(negedge clk);
          chk("wb_mem_write", mem_write, 1);
          chk("wb_mem_read", mem_read, 0);
          chk("wb_mem_addr", mem_addr, {m_tag[idx], idx});
          chk("wb_mem_wdata", mem_wdata, m_data[idx]);
          if (proc_stall) stalls++;
          @(posedge clk); #1;
        end
        mem[{m_tag[idx], idx}] = m_data[idx];
      end
      for (int c = 0; c <= d_al; c++) begin
        mem_ready = (c == d_al);
        mem_rdata = mem_ready ? mem_line({tg, idx}) : {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        chk("al_mem_read", mem_read, 1);
        chk("al_mem_write", mem_write, 0);
        chk("al_mem_addr", mem_addr, {tg, idx});
        chk("al_mem_wdata", mem_wdata, 0);
        if (proc_stall) stalls++;
        @(posedge clk); #1;
      end
      m_valid[idx] = 1;
      m_dirty[idx] = 0;
      m_tag[idx]   = tg;
      m_data[idx]  = mem[{tg, idx}];
      mem_rdata    = {$urandom, $urandom, $urandom, $urandom};
    end
    mem_ready = spur;
    @(negedge clk);
    chk("hit_stall", proc_stall, 0);
    if (!hit) chk("stall_len", stalls, 2 + d_al + (wb ? d_wb + 1 : 0));
    if (rd && !wr) chk("rdata", proc_rdata, m_data[idx][w*32 +: 32]);
    chk("idle_mem_rw", {mem_read, mem_write}, 0);
    chk("idle_mem_addr", mem_addr, 0);
    @(posedge clk); #1;
    if (wr) begin
      m_data[idx][w*32 +: 32] = wd;
      m_dirty[idx] = 1;
    end
    proc_read = 0; proc_write = 0; mem_ready = 0;
  endtask

  initial begin
    logic [29:0] ra;
    int          op;
    model_clear();
    #12;
    chk("rst_stall", proc_stall, 0);
    chk("rst_rdata", proc_rdata, 0);
    chk("rst_mem_rw", {mem_read, mem_write}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed sequence around line 4 and line 0.
    mem[28'h4] = {32'hD, 32'hC, 32'hB, 32'hA};
    access(1, 0, 30'h10, 32'h0, 0, 0, 0);
    access(0, 1, 30'h11, 32'h12345678, 0, 0, 0);
    access(1, 0, 30'h11, 32'h0, 0, 0, 1);
    access(1, 0, 30'h30, 32'h0, 2, 1, 0);
    chk("wb_stored", mem[28'h4], {32'hD, 32'hC, 32'h12345678, 32'hA});
    access(0, 1, 30'h20, 32'hCAFEF00D, 0, 2, 0);
    chk("wmiss_dirty", m_dirty[0], 1);
    access(1, 0, 30'h21, 32'h0, 0, 0, 0);
    access(1, 0, 30'h20, 32'h0, 0, 0, 0);
    access(1, 0, 30'h00, 32'h0, 1, 0, 0);
    access(1, 0, 30'h10, 32'h0, 0, 3, 0);

    // Clean-miss stall lengths 2, 3 and 9.
    access(1, 0, 30'h04, 32'h0, 0, 0, 0);
    access(1, 0, 30'h08, 32'h0, 0, 1, 0);
    access(1, 0, 30'h0C, 32'h0, 0, 7, 0);

    // Reset in the middle of a clean allocate.
    proc_read = 1; proc_addr = 30'h24;
    @(posedge clk); #1;
    chk("pre_rst_mem_read", mem_read, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_mem_read", mem_read, 0);
    chk("async_rst_mem_addr", mem_addr, 0);
    chk("async_rst_rdata", proc_rdata, 0);
    proc_read = 0;
    model_clear();
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle_stall", proc_stall, 0);
    @(posedge clk); #1;
    access(1, 0, 30'h04, 32'h0, 0, 1, 0);

    // Random traffic with a small tag range to force conflicts.
    for (int n = 0; n < 300; n++) begin
      ra = {25'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      op = $urandom_range(0, 4);
      if (op == 4) begin
        mem_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("rand_idle_stall", proc_stall, 0);
        chk("rand_idle_mem_rw", {mem_read, mem_write}, 0);
        @(posedge clk); #1 mem_ready = 0;
      end else begin
        access(op != 1, op != 0 && op != 3, ra, $urandom,
               $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
